// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes on both sides.
//
// Function
//   One op per cycle for logic, arithmetic and compare ops.
//   Shifts use a small iterative shifter and stall upstream until they finish.
//
// Optional build macro
//   ALU_FAST_SHIFT_EN: shifts use a single-cycle barrel shifter, and every op
//   has latency 1. SHIFT is never entered, busy is tied low and SHIFT_STEP has
//   no effect.
//
// Ports
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid, in_ready  upstream handshake (in_ready is combinational from out_ready)
//   Operation           4-bit ALU operation code
//   SrcA, SrcB          operands; SrcB[log2(DATA_W)-1:0] is the shift amount
//   out_valid, out_ready downstream handshake
//   ALUResult, Zero     registered result and its zero flag
//   busy                high while an iterative shift is in progress
module alu_exec_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero,
  output logic              busy
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_NE   = 4'b0110;
  localparam logic [3:0] OP_EQ   = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              out_valid_q, out_valid_d;
  logic [SH_W-1:0]   amt;
  logic              is_shift;
  logic              xfer;

  assign amt      = SrcB[SH_W-1:0];
  assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);

  // Accept in IDLE, or in HOLD when the held result leaves this same cycle.
  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign xfer     = in_valid && in_ready;

  // Single-cycle result for everything except iterative shifts.
  function automatic logic [DATA_W-1:0] alu_op(input logic [3:0]        op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_EQ:   r = {{(DATA_W-1){1'b0}}, (a == b)};
      OP_NE:   r = {{(DATA_W-1){1'b0}}, (a != b)};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  r = a << b[SH_W-1:0];
      OP_SRL:  r = a >> b[SH_W-1:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[SH_W-1:0]);
`else
      // Only reached with a zero shift amount; nonzero amounts iterate.
      OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

`ifndef ALU_FAST_SHIFT_EN
  localparam logic [SH_W-1:0] STEP = SH_W'(SHIFT_STEP);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [SH_W-1:0]   rem_q, rem_d;
  logic [3:0]        op_q, op_d;
  logic              busy_q, busy_d;
  logic [SH_W-1:0]   step_amt;
  logic [DATA_W-1:0] shifted;

  // Full step while enough remains, otherwise just the remainder.
  assign step_amt = (rem_q < STEP) ? rem_q : STEP;

  // One shifter iteration; SRA keeps the original MSB because acc_q[MSB] never changes.
  always_comb begin
    shifted = acc_q;
    case (op_q)
      OP_SLL:  shifted = acc_q << step_amt;
      OP_SRL:  shifted = acc_q >> step_amt;
      OP_SRA:  shifted = $unsigned($signed(acc_q) >>> step_amt);
      default: shifted = acc_q;
    endcase
  end

  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
`ifndef ALU_FAST_SHIFT_EN
    acc_d       = acc_q;
    rem_d       = rem_q;
    op_d        = op_q;
    busy_d      = busy_q;
`endif
    case (state_q)
      IDLE, HOLD: begin
        if ((state_q == HOLD) && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
        if (xfer) begin
`ifndef ALU_FAST_SHIFT_EN
          if (is_shift && (amt != '0)) begin
            state_d     = SHIFT;
            acc_d       = SrcA;
            rem_d       = amt;
            op_d        = Operation;
            busy_d      = 1'b1;
            out_valid_d = 1'b0;
          end else
`endif
          begin
            state_d     = HOLD;
            result_d    = alu_op(Operation, SrcA, SrcB);
            zero_d      = (result_d == '0);
            out_valid_d = 1'b1;
          end
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      SHIFT: begin
        acc_d = shifted;
        rem_d = rem_q - step_amt;
        if (rem_d == '0) begin
          state_d     = HOLD;
          result_d    = shifted;
          zero_d      = (shifted == '0);
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      acc_q       <= '0;
      rem_q       <= '0;
      op_q        <= '0;
      busy_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
`ifndef ALU_FAST_SHIFT_EN
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      op_q        <= op_d;
      busy_q      <= busy_d;
`endif
    end
  end

  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed stimulus for alu_exec_unit with a queue-based
// reference model checked on every cycle out_valid is high, plus literal checks.
module tb_alu_exec_unit;

  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, XOR_ = 4'b0010, ADD_ = 4'b0011;
  localparam logic [3:0] SUB_ = 4'b1000, SLL_ = 4'b0100, SRL_ = 4'b0101, SRA_ = 4'b1011;
  localparam logic [3:0] SLT_ = 4'b1111, SLTU_ = 4'b1001, EQ_ = 4'b0111, NE_ = 4'b0110;

`ifdef ALU_FAST_SHIFT_EN
  localparam int SLL31_BUSY = 0;
`else
  localparam int SLL31_BUSY = 31;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  Operation = 4'b0000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;

  alu_exec_unit #(.DATA_W(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .Zero(Zero), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          cyc;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the operation table.
  function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned amt;
    logic [31:0] r;
    amt = b % 32;
    case (op)
      AND_:  return a & b;
      OR_:   return a | b;
      XOR_:  return a ^ b;
      ADD_:  return a + b;
      SUB_:  return a - b;
      SLL_:  return a << amt;
      SRL_:  return a >> amt;
      SRA_: begin
        r = a >> amt;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> amt);
        return r;
      end
      SLT_:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU_: return (a < b) ? 32'd1 : 32'd0;
      EQ_:   return (a == b) ? 32'd1 : 32'd0;
      NE_:   return (a != b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Cycles from transfer to first out_valid cycle (step of one bit per cycle).
  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    if ((op == SLL_ || op == SRL_ || op == SRA_) && (b % 32) != 0) return int'(b % 32) + 1;
    return 1;
`endif
  endfunction

  // Track transfers in and results out.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      cyc++;
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready)
        q.push_back('{model_res(Operation, SrcA, SrcB), model_lat(Operation, SrcB), cyc});
    end
  end

  // Compare DUT outputs against the model whenever a result is presented.
  logic prev_v = 1'b0;
  logic prev_hs = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          check("model_result", ALUResult, q[0].res);
          check("model_zero", Zero, (q[0].res == 0));
          if (!prev_v || prev_hs) check("model_latency", cyc - q[0].cyc, q[0].lat - 1);
        end
      end
      prev_v  = out_valid;
      prev_hs = out_valid && out_ready;
    end
  end

  // Present an op and hold it until accepted; returns just after the transfer edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic rdy;
    int   n;
    n = 0;
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 200);
    in_valid = 1'b0;
    if (!rdy) check("issue_timeout", rdy, 1);
  endtask

  // Wait for out_valid and check the literal expectation; consumes the result.
  task automatic wait_result(input string name, input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({name, "_valid"}, out_valid, 1);
    check({name, "_result"}, ALUResult, exp);
    check({name, "_zero"}, Zero, (exp == 0));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  logic [3:0]  c_op  [5] = '{SLT_, SLTU_, EQ_, NE_, 4'b1110};
  logic [31:0] c_a   [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 32'h1234, 32'hDEAD_BEEF};
  logic [31:0] c_b   [5] = '{32'd1, 32'd1, 32'h1234, 32'h1234, 32'h1234_5678};
  logic [31:0] c_exp [5] = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0};

  initial begin
    int busy_cnt;
    int stable_cnt;
    int n;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", ALUResult, 0);
    check("rst_zero", Zero, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // ADD overflow then SUB back-to-back.
    Operation = ADD_; SrcA = 32'h7FFF_FFFF; SrcB = 32'h1; in_valid = 1'b1;
    @(negedge clk);
    check("add_in_ready", in_ready, 1);
    @(posedge clk); #1;
    Operation = SUB_; SrcA = 32'd5; SrcB = 32'd5;
    @(negedge clk);
    check("add_valid", out_valid, 1);
    check("add_result", ALUResult, 32'h8000_0000);
    check("add_zero", Zero, 0);
    check("sub_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("sub_valid", out_valid, 1);
    check("sub_result", ALUResult, 32'h0);
    check("sub_zero", Zero, 1);
    @(posedge clk); #1;

    // SLL by 31: busy and stalled for 31 cycles.
    issue(SLL_, 32'h1, 32'd31);
    busy_cnt = 0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      if (busy && !in_ready) busy_cnt++;
      n++;
      @(negedge clk);
    end
    check("sll_busy_cycles", busy_cnt, SLL31_BUSY);
    check("sll_valid", out_valid, 1);
    check("sll_result", ALUResult, 32'h8000_0000);
    @(posedge clk); #1;

    // Right shifts and a zero-amount shift.
    issue(SRA_, 32'hF000_0000, 32'd4);
    wait_result("sra", 32'hFF00_0000);
    issue(SRL_, 32'hF000_0000, 32'd4);
    wait_result("srl", 32'h0F00_0000);
    issue(SLL_, 32'h1234_5678, 32'd32);
    wait_result("sll_amt0", 32'h1234_5678);

    // Backpressure, then release together with a new op.
    out_ready = 1'b0;
    issue(XOR_, 32'hFF00_FF00, 32'h0F0F_0F0F);
    stable_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid && ALUResult === 32'hF00F_F00F && Zero === 1'b0 && !in_ready) stable_cnt++;
    end
    check("xor_hold_cycles", stable_cnt, 5);
    @(posedge clk); #1;
    out_ready = 1'b1;
    Operation = AND_; SrcA = 32'hFFFF_0000; SrcB = 32'h0F0F_0F0F; in_valid = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", in_ready, 1);
    check("b2b_xor_result", ALUResult, 32'hF00F_F00F);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("and", 32'h0F0F_0000);

    // Compare ops and an unused code.
    for (int i = 0; i < 5; i++) begin
      issue(c_op[i], c_a[i], c_b[i]);
      wait_result($sformatf("cmp%0d", i), c_exp[i]);
    end

    // Asynchronous reset in the middle of a shift.
    issue(SLL_, 32'h1, 32'd20);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", ALUResult, 0);
    check("midrst_busy", busy, 0);
    check("midrst_zero", Zero, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1);
    check("postrst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    issue(ADD_, 32'd3, 32'd4);
    wait_result("postrst_add", 32'd7);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
